// File: rtl/acc_stack_regfile_if.sv
// Bus bundle for the accumulator/register-file block: control and write data in,
// read data, accumulator and save-stack status out.
interface acc_stack_regfile_if #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int CW = 3
);
  logic          wen;
  logic [2:0]    acc_ctl;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] wd;
  logic          acc_push;
  logic          acc_pop;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic [DW-1:0] acc_q;
  logic          stk_full;
  logic          stk_empty;
  logic [CW-1:0] stk_cnt;
  logic          stk_err;

  modport master (
    output wen, acc_ctl, ra1, ra2, wd, acc_push, acc_pop,
    input  rd1, rd2, acc_q, stk_full, stk_empty, stk_cnt, stk_err
  );

  modport slave (
    input  wen, acc_ctl, ra1, ra2, wd, acc_push, acc_pop,
    output rd1, rd2, acc_q, stk_full, stk_empty, stk_cnt, stk_err
  );
endinterface

// File: rtl/acc_stack_regfile.sv
// General register file plus an accumulator with a LIFO save stack.
// Reads are combinational from pre-edge state; all updates on the rising clock edge.
module acc_stack_regfile #(
  parameter int DW     = 8,
  parameter int NREG   = 8,
  parameter int SDEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  acc_stack_regfile_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(SDEPTH + 1);
  localparam int SW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(SDEPTH);

  logic [DW-1:0] rf  [NREG];
  logic [DW-1:0] stk [SDEPTH];
  logic [DW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          err;

  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop_req;
  logic          push_ok;
  logic          pop_ok;
  logic          misuse;
  logic [CW-1:0] cnt_m1;
  logic [SW-1:0] push_idx;
  logic [SW-1:0] pop_idx;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;

  assign ra1      = bus.ra1;
  assign ra2      = bus.ra2;
  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign push_req = bus.acc_push & ~bus.acc_pop;
  assign pop_req  = bus.acc_pop & ~bus.acc_push;
  assign push_ok  = push_req & ~full;
  assign pop_ok   = pop_req & ~empty;
  // Simultaneous push+pop is treated as misuse, same as overflow/underflow.
  assign misuse   = (bus.acc_push & bus.acc_pop) | (push_req & full) | (pop_req & empty);
  assign cnt_m1   = cnt - CW'(1);
  assign push_idx = cnt[SW-1:0];
  assign pop_idx  = cnt_m1[SW-1:0];

  always_comb begin
    rd1 = rf[ra1];
    rd2 = rf[ra2];
    case (bus.acc_ctl[1:0])
      2'b01:   rd2 = acc;
      2'b10:   rd1 = acc;
      2'b11: begin
        rd1 = acc;
        rd2 = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      for (int i = 0; i < SDEPTH; i++) stk[i] <= '0;
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (bus.wen && bus.acc_ctl[2]) rf[ra2] <= bus.wd;

      // A restore from the stack wins over a same-cycle accumulator write.
      if (pop_ok)                          acc <= stk[pop_idx];
      else if (bus.wen && !bus.acc_ctl[2]) acc <= bus.wd;

      if (push_ok) begin
        stk[push_idx] <= acc;
        cnt           <= cnt + CW'(1);
      end else if (pop_ok) begin
        cnt <= cnt_m1;
      end

      if (misuse) err <= 1'b1;
    end
  end

  assign bus.rd1       = rd1;
  assign bus.rd2       = rd2;
  assign bus.acc_q     = acc;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_cnt   = cnt;
  assign bus.stk_err   = err;
endmodule

// File: tb/tb_acc_stack_regfile.sv
// Self-checking bench: table of vectors with hand-derived expectations, post-edge
// results queued at drive time and popped after the edge for comparison.
module tb_acc_stack_regfile;
  localparam int DW = 8;
  localparam int NREG = 8;
  localparam int SDEPTH = 4;
  localparam int AW = 3;
  localparam int CW = 3;

  typedef struct {
    logic          rst;
    logic          wen;
    logic [2:0]    ctl;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] wd;
    logic          push;
    logic          pop;
    logic          chk_rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];
  exp_t exp_q[$];

  acc_stack_regfile_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

  acc_stack_regfile #(.DW(DW), .NREG(NREG), .SDEPTH(SDEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic w, input logic [2:0] c,
                              input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                              input logic [DW-1:0] d, input logic pu, input logic po,
                              input logic ck, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                              input logic [DW-1:0] ea, input logic [CW-1:0] ec, input logic ee);
    vec_t v;
    v.rst = r; v.wen = w; v.ctl = c; v.ra1 = a1; v.ra2 = a2; v.wd = d;
    v.push = pu; v.pop = po; v.chk_rd = ck; v.rd1 = e1; v.rd2 = e2;
    v.acc = ea; v.cnt = ec; v.err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    bus.wen      = v.wen;
    bus.acc_ctl  = v.ctl;
    bus.ra1      = v.ra1;
    bus.ra2      = v.ra2;
    bus.wd       = v.wd;
    bus.acc_push = v.push;
    bus.acc_pop  = v.pop;
    #1;
    if (v.chk_rd) begin
      chk($sformatf("rd1[%0d]", idx), 32'(bus.rd1), 32'(v.rd1));
      chk($sformatf("rd2[%0d]", idx), 32'(bus.rd2), 32'(v.rd2));
    end
    e.acc = v.acc; e.cnt = v.cnt; e.err = v.err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk($sformatf("queue[%0d]", idx), 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("acc_q[%0d]", idx), 32'(bus.acc_q), 32'(e.acc));
      chk($sformatf("stk_cnt[%0d]", idx), 32'(bus.stk_cnt), 32'(e.cnt));
      chk($sformatf("stk_err[%0d]", idx), 32'(bus.stk_err), 32'(e.err));
      chk($sformatf("stk_full[%0d]", idx), 32'(bus.stk_full), 32'(e.cnt == CW'(SDEPTH)));
      chk($sformatf("stk_empty[%0d]", idx), 32'(bus.stk_empty), 32'(e.cnt == '0));
    end
  endtask

  // Hand-written multi-cycle sequences go through the same path as the table.
  task automatic step(input logic r, input logic w, input logic [2:0] c,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] d, input logic pu, input logic po,
                      input logic ck, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                      input logic [DW-1:0] ea, input logic [CW-1:0] ec, input logic ee,
                      input int idx);
    apply(mk(r, w, c, a1, a2, d, pu, po, ck, e1, e2, ea, ec, ee), idx);
  endtask

  initial begin
    bus.wen = 1'b0; bus.acc_ctl = 3'b000; bus.ra1 = '0; bus.ra2 = '0;
    bus.wd = '0; bus.acc_push = 1'b0; bus.acc_pop = 1'b0;

    //                rst wen ctl     ra1 ra2 wd     pu po  ck rd1    rd2    acc    cnt err
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 3, 8'h5A, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 3, 0, 8'h00, 0, 0, 1, 8'h5A, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 3'b010, 3, 0, 8'h11, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 3'b001, 3, 3, 8'h00, 0, 0, 1, 8'h5A, 8'h11, 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 3'b011, 3, 3, 8'h00, 0, 0, 1, 8'h11, 8'h11, 8'h11, 0, 0));
    tbl.push_back(mk(0, 0, 3'b010, 3, 3, 8'h00, 0, 0, 1, 8'h11, 8'h5A, 8'h11, 0, 0));
    tbl.push_back(mk(0, 1, 3'b000, 0, 0, 8'h22, 1, 0, 1, 8'h00, 8'h00, 8'h22, 1, 0));
    tbl.push_back(mk(0, 0, 3'b011, 0, 0, 8'h00, 0, 1, 1, 8'h22, 8'h22, 8'h11, 0, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Fill to full, overflow, then drain past empty.
    step(0, 1, 3'b000, 0, 0, 8'h01, 0, 0, 0, 0, 0, 8'h01, 0, 0, 100);
    step(0, 1, 3'b000, 0, 0, 8'h02, 1, 0, 0, 0, 0, 8'h02, 1, 0, 101);
    step(0, 1, 3'b000, 0, 0, 8'h03, 1, 0, 0, 0, 0, 8'h03, 2, 0, 102);
    step(0, 1, 3'b000, 0, 0, 8'h04, 1, 0, 0, 0, 0, 8'h04, 3, 0, 103);
    step(0, 1, 3'b000, 0, 0, 8'h05, 1, 0, 0, 0, 0, 8'h05, 4, 0, 104);
    step(0, 0, 3'b000, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h05, 4, 1, 105);
    step(0, 0, 3'b000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h04, 3, 1, 106);
    step(0, 0, 3'b000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h03, 2, 1, 107);
    step(0, 0, 3'b000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h02, 1, 1, 108);
    step(0, 0, 3'b000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h01, 0, 1, 109);
    step(0, 0, 3'b011, 0, 0, 8'h00, 0, 1, 1, 8'h01, 8'h01, 8'h01, 0, 1, 110);

    // Push+pop conflict, pop beating an acc write, pop alongside an rf write.
    step(1, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 200);
    step(0, 1, 3'b000, 0, 0, 8'hA1, 0, 0, 0, 0, 0, 8'hA1, 0, 0, 201);
    step(0, 1, 3'b000, 0, 0, 8'hA2, 1, 0, 0, 0, 0, 8'hA2, 1, 0, 202);
    step(0, 1, 3'b000, 0, 0, 8'hA3, 1, 0, 0, 0, 0, 8'hA3, 2, 0, 203);
    step(0, 0, 3'b000, 0, 0, 8'h00, 1, 1, 0, 0, 0, 8'hA3, 2, 1, 204);
    step(0, 1, 3'b000, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 8'hA2, 1, 1, 205);
    step(0, 1, 3'b100, 0, 5, 8'h77, 0, 1, 0, 0, 0, 8'hA1, 0, 1, 206);
    step(0, 0, 3'b000, 5, 5, 8'h00, 0, 0, 1, 8'h77, 8'h77, 8'hA1, 0, 1, 207);

    // Underflow error, build depth 3, then reset with a pending write and push.
    step(1, 0, 3'b000, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 300);
    step(0, 1, 3'b100, 0, 3, 8'h5A, 0, 1, 0, 0, 0, 8'h00, 0, 1, 301);
    step(0, 1, 3'b000, 0, 0, 8'hB1, 0, 0, 0, 0, 0, 8'hB1, 0, 1, 302);
    step(0, 1, 3'b000, 0, 0, 8'hB2, 1, 0, 0, 0, 0, 8'hB2, 1, 1, 303);
    step(0, 1, 3'b000, 0, 0, 8'hB3, 1, 0, 0, 0, 0, 8'hB3, 2, 1, 304);
    step(0, 1, 3'b000, 0, 0, 8'hB4, 1, 0, 0, 0, 0, 8'hB4, 3, 1, 305);
    step(1, 1, 3'b100, 0, 2, 8'hEE, 1, 0, 0, 0, 0, 8'h00, 0, 0, 306);
    step(0, 0, 3'b000, 3, 2, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 307);
    step(0, 0, 3'b000, 0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 1, 308);

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acc_stack_regfile.md
ACC_STACK_REGFILE -- requirements
Module: acc_stack_regfile

Interface
REQ-001 SHALL have parameter DW, default 8, register and accumulator data width.
REQ-002 SHALL have parameter NREG, default 8, general register count (power of two, >=2).
REQ-003 SHALL have parameter SDEPTH, default 4, accumulator save-stack depth (>=1).
REQ-004 SHALL derive AW = clog2(NREG) and CW = clog2(SDEPTH+1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wen  input  1  write enable.
REQ-008 SHALL have port acc_ctl  input  3  bit2 write target (1 = rf[ra2], 0 = acc); bits1:0 read mode.
REQ-009 SHALL have ports ra1, ra2  input  AW  read/write register addresses.
REQ-010 SHALL have port wd  input  DW  write data.
REQ-011 SHALL have port acc_push  input  1  save acc to stack.
REQ-012 SHALL have port acc_pop  input  1  restore acc from stack.
REQ-013 SHALL have ports rd1, rd2  output  DW  combinational read data.
REQ-014 SHALL have port acc_q  output  DW  current accumulator value.
REQ-015 SHALL have ports stk_full, stk_empty  output  1  stack occupancy flags.
REQ-016 SHALL have port stk_cnt  output  CW  stack entry count.
REQ-017 SHALL have port stk_err  output  1  sticky stack-misuse flag.

Function
REQ-018 SHALL, when wen=1 and acc_ctl[2]=1, write wd to rf[ra2] at the edge; acc unaffected by this write.
REQ-019 SHALL, when wen=1 and acc_ctl[2]=0, write wd to acc at the edge unless a valid pop occurs (REQ-024).
REQ-020 SHALL hold all rf entries and acc when wen=0 and no valid pop.
REQ-021 SHALL drive reads by acc_ctl[1:0]: 00 rd1=rf[ra1], rd2=rf[ra2]; 01 rd1=rf[ra1], rd2=acc; 10 rd1=acc, rd2=rf[ra2]; 11 rd1=rd2=acc.
REQ-022 SHALL provide reads from pre-edge state (no write-to-read bypass); acc_q = acc at all times.
REQ-023 SHALL, on valid push (acc_push=1, acc_pop=0, stk_cnt<SDEPTH), store pre-edge acc at stack[stk_cnt] and increment stk_cnt; same-cycle acc write still applies to acc.
REQ-024 SHALL, on valid pop (acc_pop=1, acc_push=0, stk_cnt>0), load acc from stack[stk_cnt-1] and decrement stk_cnt; pop overrides same-cycle acc write; rf write (acc_ctl[2]=1) still applies.
REQ-025 SHALL ignore push when full, pop when empty, and push+pop together (no state change to stack or acc from them), setting stk_err=1 at that edge.
REQ-026 SHALL keep stk_err set until rst.
REQ-027 SHALL drive stk_empty = (stk_cnt==0), stk_full = (stk_cnt==SDEPTH), combinationally from stk_cnt.
REQ-028 SHALL truncate nothing: all data paths exactly DW bits; out-of-range never occurs as addresses are AW bits.

Reset
REQ-029 SHALL, on rising edge with rst=1, clear all rf entries, acc, all stack entries, stk_cnt and stk_err to 0; rst overrides wen, push, pop in that cycle.
REQ-030 SHALL present after reset: rd1=rd2=acc_q=0, stk_empty=1, stk_full=0, stk_err=0.

Verification
REQ-031 SHALL check: reset, then wen=1, acc_ctl=100, ra2=3, wd=0x5A; next cycle acc_ctl=000, ra1=3 -> rd1=0x5A, acc_q=0.
REQ-032 SHALL check: wen=1, acc_ctl=010, wd=0x11; then acc_ctl=001, ra1=3 -> rd2=0x11, rd1=rf[3]; mode 11 -> rd1=rd2=0x11.
REQ-033 SHALL check: acc=0x11, push with wen acc write wd=0x22 same cycle -> stack[0]=0x11, acc=0x22, stk_cnt=1; pop -> acc=0x11, stk_empty=1.
REQ-034 SHALL check: SDEPTH=4, five pushes of 1..5 -> stk_full=1 after 4th, 5th ignored, stk_err=1; four pops return 4,3,2,1; fifth pop ignored, acc=1.
REQ-035 SHALL check: push+pop same cycle with stk_cnt=2 -> stk_cnt stays 2, acc unchanged, stk_err=1; pop with wen acc write wd=0xFF -> acc=popped value, not 0xFF.
REQ-036 SHALL check: rst asserted mid-sequence with stk_cnt=3, stk_err=1, wen=1 -> next cycle all state 0, write discarded.
